// File: rtl/csl_pkg.sv
// Shared constants, FSM state codes and index-width helper for the sequential wide adder.
package csl_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Word-index width for a given word count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/csl32_bit.sv
// 32-bit carry-select adder slice: low half ripples, high half is precomputed for both carries.
module csl32_bit
  import csl_pkg::*;
(
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              cin,
  output logic              COUT,
  output logic [WORD_W-1:0] sum
);

  localparam int unsigned HALF_W  = WORD_W / 2;
  localparam int unsigned HALF_P1 = HALF_W + 1;

  logic [HALF_W:0] w_lo;
  logic [HALF_W:0] w_hi0;
  logic [HALF_W:0] w_hi1;

  assign w_lo  = {1'b0, A[HALF_W-1:0]} + {1'b0, B[HALF_W-1:0]} + HALF_P1'(cin);
  assign w_hi0 = {1'b0, A[WORD_W-1:HALF_W]} + {1'b0, B[WORD_W-1:HALF_W]};
  assign w_hi1 = w_hi0 + HALF_P1'(1);

  // Low-half carry picks which precomputed upper half is used.
  assign sum[HALF_W-1:0]               = w_lo[HALF_W-1:0];
  assign {COUT, sum[WORD_W-1:HALF_W]}  = w_lo[HALF_W] ? w_hi1 : w_hi0;

endmodule

// File: rtl/csl_wide_adder_seq.sv
// WORDS x 32-bit adder that streams one word per cycle (LSW first) through a single csl32_bit slice.
// Optional signed-overflow output is enabled by defining CSL_OVF_EN.
module csl_wide_adder_seq
  import csl_pkg::*;
#(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned W     = WORD_W * WORDS
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef CSL_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned      IDX_W    = idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  int unsigned       w_base;
  logic [WORD_W-1:0] w_slice_sum;
  logic              w_slice_cout;
`ifdef CSL_OVF_EN
  logic              r_ovf;
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (r_idx == LAST_IDX) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register with registered handshake flags derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign w_base = WORD_W * 32'(r_idx);

  csl32_bit u_slice (
    .A    (r_a[w_base +: WORD_W]),
    .B    (r_b[w_base +: WORD_W]),
    .cin  (r_carry),
    .COUT (w_slice_cout),
    .sum  (w_slice_sum)
  );

  // Operand capture, per-word accumulation and final carry/overflow latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef CSL_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[w_base +: WORD_W] <= w_slice_sum;
          r_carry                 <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_cout <= w_slice_cout;
`ifdef CSL_OVF_EN
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[WORD_W-1] != r_a[W-1]);
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef CSL_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_csl_wide_adder_seq.sv
// Self-checking bench for csl_wide_adder_seq: directed table, multi-cycle corner cases, random vs. arithmetic model.
module tb_csl_wide_adder_seq;

  logic clk = 1'b0;
  logic rst;

  logic         in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
  logic [127:0] a4, b4, sum4;
  logic         in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
  logic [63:0]  a2, b2, sum2;
`ifdef CSL_OVF_EN
  logic         ovf4, ovf2;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic [127:0] s;
    logic         c;
    logic         o;
  } vec_t;

  typedef struct {
    logic [127:0] s;
    logic         c;
    logic         o;
  } exp_t;

  always #5 clk = ~clk;

  csl_wide_adder_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4)
`ifdef CSL_OVF_EN
    , .ovf(ovf4)
`endif
  );

  csl_wide_adder_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
`ifdef CSL_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic set_in(input int sel, input logic v, input logic [127:0] da,
                        input logic [127:0] db, input logic dc);
    if (sel == 0) begin
      in_valid4 = v; a4 = da; b4 = db; cin4 = dc;
    end else begin
      in_valid2 = v; a2 = da[63:0]; b2 = db[63:0]; cin2 = dc;
    end
  endtask

  task automatic set_ordy(input int sel, input logic o);
    if (sel == 0) out_ready4 = o;
    else          out_ready2 = o;
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? out_valid4 : out_valid2;
  endfunction

  function automatic logic get_ir(input int sel);
    return (sel == 0) ? in_ready4 : in_ready2;
  endfunction

  function automatic logic get_cout(input int sel);
    return (sel == 0) ? cout4 : cout2;
  endfunction

  function automatic logic [127:0] get_sum(input int sel);
    return (sel == 0) ? sum4 : {64'b0, sum2};
  endfunction

`ifdef CSL_OVF_EN
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? ovf4 : ovf2;
  endfunction
`endif

  // Word-wise random operand biased toward all-zero and all-one words to stress carries.
  function automatic logic [127:0] rand_op();
    logic [127:0] r;
    r = '0;
    for (int w = 0; w < 4; w++) begin
      case ($urandom_range(0, 3))
        0:       r[w*32 +: 32] = 32'h0000_0000;
        1:       r[w*32 +: 32] = 32'hFFFF_FFFF;
        default: r[w*32 +: 32] = $urandom();
      endcase
    end
    return r;
  endfunction

  // One operation on the 4-word instance; returns result and accept-to-valid latency.
  task automatic do_op(input logic [127:0] da, input logic [127:0] db, input logic dc,
                       output logic [127:0] rs, output logic rc, output int lat);
    int cyc;
    set_in(0, 1'b1, da, db, dc);
    chk("accept_in_ready", 129'(in_ready4), 129'(1));
    @(negedge clk);
    set_in(0, 1'b0, '0, '0, 1'b0);
    cyc = 1;
    while (!out_valid4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid4) fail_now("op_timeout");
    rs  = sum4;
    rc  = cout4;
    lat = cyc;
  endtask

  task automatic consume();
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("consume_out_valid", 129'(out_valid4), 129'(0));
    chk("consume_in_ready", 129'(in_ready4), 129'(1));
  endtask

  // Random handshakes with stalls, checked against plain a+b+cin arithmetic.
  task automatic run_random(input int sel, input int n_ops);
    int           nbits;
    logic [127:0] mask;
    logic [127:0] ra, rb;
    logic         rc, pend, ordy;
    logic [128:0] full;
    exp_t         q[$];
    exp_t         e;
    int           sent, got, cyc;
    nbits = (sel == 0) ? 128 : 64;
    mask  = (sel == 0) ? {128{1'b1}} : {64'b0, {64{1'b1}}};
    ra = '0; rb = '0; rc = 1'b0; pend = 1'b0;
    sent = 0; got = 0; cyc = 0;
    while (got < n_ops && cyc < 30000) begin
      if (!pend && sent < n_ops && $urandom_range(0, 3) != 0) begin
        ra   = rand_op() & mask;
        rb   = rand_op() & mask;
        rc   = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      ordy = ($urandom_range(0, 2) != 0);
      set_in(sel, pend, ra, rb, rc);
      set_ordy(sel, ordy);
      if (pend && get_ir(sel)) begin
        full = 129'(ra) + 129'(rb) + 129'(rc);
        e.s  = full[127:0] & mask;
        e.c  = full[nbits];
        e.o  = (ra[nbits-1] == rb[nbits-1]) && (e.s[nbits-1] != ra[nbits-1]);
        q.push_back(e);
        sent++;
        pend = 1'b0;
      end
      if (get_ov(sel) && ordy) begin
        if (q.size() == 0) begin
          chk("rand_unexpected_result", 129'(1), 129'(0));
        end else begin
          e = q.pop_front();
          chk("rand_sum", 129'(get_sum(sel)), 129'(e.s));
          chk("rand_cout", 129'(get_cout(sel)), 129'(e.c));
`ifdef CSL_OVF_EN
          chk("rand_ovf", 129'(get_ovf(sel)), 129'(e.o));
`endif
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n_ops) fail_now("rand_timeout");
    set_in(sel, 1'b0, '0, '0, 1'b0);
    set_ordy(sel, 1'b0);
    chk("rand_drain", 129'(q.size()), 129'(0));
    @(negedge clk);
    chk("rand_no_extra", 129'(get_ov(sel)), 129'(0));
  endtask

  initial begin
    vec_t         tbl[6];
    logic [127:0] rs;
    logic         rc;
    int           lat;

    tbl[0] = '{{128{1'b1}}, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
    tbl[1] = '{128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
               128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0};
    tbl[2] = '{128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{{128{1'b1}}, {128{1'b1}}, 1'b1, {128{1'b1}}, 1'b1, 1'b0};
    tbl[4] = '{128'h8000_0000_0000_0000_0000_0000_0000_0000,
               128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 128'd0, 1'b1, 1'b1};
    tbl[5] = '{128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b1,
               128'h0000_0002_0000_0000_0000_0000_0000_0001, 1'b0, 1'b0};

    rst = 1'b1;
    set_in(0, 1'b0, '0, '0, 1'b0);
    set_in(1, 1'b0, '0, '0, 1'b0);
    out_ready4 = 1'b0;
    out_ready2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 129'(out_valid4), 129'(0));
    chk("reset_in_ready", 129'(in_ready4), 129'(1));
    chk("reset_sum", 129'(sum4), 129'(0));
    chk("reset_cout", 129'(cout4), 129'(0));
    chk("reset_in_ready_w2", 129'(in_ready2), 129'(1));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, lat);
      chk($sformatf("vec%0d_sum", i), 129'(rs), 129'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), 129'(rc), 129'(tbl[i].c));
      chk($sformatf("vec%0d_latency", i), 129'(lat), 129'(5));
`ifdef CSL_OVF_EN
      chk($sformatf("vec%0d_ovf", i), 129'(ovf4), 129'(tbl[i].o));
`endif
      consume();
    end

    // Stall in DONE: result stable, no acceptance of a new operand.
    do_op(128'd5, 128'd7, 1'b1, rs, rc, lat);
    chk("hold_first_sum", 129'(rs), 129'(13));
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1, 128'd100, 128'd200, 1'b0);
      @(negedge clk);
      chk("hold_sum", 129'(sum4), 129'(13));
      chk("hold_out_valid", 129'(out_valid4), 129'(1));
      chk("hold_in_ready", 129'(in_ready4), 129'(0));
    end
    set_in(0, 1'b0, '0, '0, 1'b0);
    consume();
    chk("hold_sum_after", 129'(sum4), 129'(13));
    @(negedge clk);
    chk("hold_nothing_captured", 129'(in_ready4), 129'(1));

    // Reset in the second RUN cycle discards the operation.
    set_in(0, 1'b1, {128{1'b1}}, 128'd1, 1'b0);
    @(negedge clk);
    set_in(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 129'(out_valid4), 129'(0));
    chk("midrst_in_ready", 129'(in_ready4), 129'(1));
    chk("midrst_sum", 129'(sum4), 129'(0));
    chk("midrst_cout", 129'(cout4), 129'(0));
    repeat (6) @(negedge clk);
    chk("midrst_no_result", 129'(out_valid4), 129'(0));
    do_op(128'd3, 128'd4, 1'b0, rs, rc, lat);
    chk("post_rst_sum", 129'(rs), 129'(7));
    chk("post_rst_cout", 129'(rc), 129'(0));
    consume();

    run_random(0, 1000);
    run_random(1, 1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
